// File: rtl/pal_pkg.sv
// rtl/pal_pkg.sv - shared state type, address-width helper and defaults for the PAL OR plane
package pal_pkg;

  localparam int PAL_DEF_NUM_INPUTS = 5;
  localparam int PAL_DEF_INIT       = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } pal_state_e;

  // Address width for an output index; never narrower than one bit.
  function automatic int pal_calc_aw(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pal_or_term.sv
// rtl/pal_or_term.sv - one OR-plane output: mask AND, reduction OR, optional register (PAL_OR_PLANE_REG_OUT_EN)
module pal_or_term #(
  parameter int NUM_INPUTS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_INPUTS-1:0] a,
  input  logic [NUM_INPUTS-1:0] mask,
  output logic                  y
);

  logic w_or;

  assign w_or = |(a & mask);

`ifdef PAL_OR_PLANE_REG_OUT_EN
  logic r_y;

  // Registered output: one cycle behind a/mask, forced low in reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_y <= 1'b0;
    end else begin
      r_y <= w_or;
    end
  end

  assign y = r_y;
`else
  logic w_unused_clk_rst;

  assign w_unused_clk_rst = clk ^ rst_n;
  assign y = w_or;
`endif

endmodule

// File: rtl/pal_or_plane.sv
// rtl/pal_or_plane.sv - PAL OR plane with shadow/active masks and restore sweep (PAL_OR_PLANE_REG_OUT_EN registers y)
module pal_or_plane
  import pal_pkg::*;
#(
  parameter int                    NUM_INPUTS  = PAL_DEF_NUM_INPUTS,
  parameter int                    NUM_OUTPUTS = 4,
  parameter logic [NUM_INPUTS-1:0] INIT        = NUM_INPUTS'(PAL_DEF_INIT),
  localparam int                   AW          = pal_calc_aw(NUM_OUTPUTS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_INPUTS-1:0]  a,
  output logic [NUM_OUTPUTS-1:0] y,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [AW-1:0]          cfg_addr,
  input  logic [NUM_INPUTS-1:0]  cfg_mask,
  input  logic                   cfg_commit,
  input  logic                   cfg_clear,
  output logic                   busy,
  output logic                   cfg_err
);

  localparam logic [AW:0]   NUM_OUT_W = (AW + 1)'(NUM_OUTPUTS);
  localparam logic [AW-1:0] LAST_IDX  = AW'(NUM_OUTPUTS - 1);

  pal_state_e              r_state;
  pal_state_e              w_state_nxt;
  logic [AW-1:0]           r_idx;
  logic                    r_cfg_err;
  logic [NUM_INPUTS-1:0]   r_shd [NUM_OUTPUTS];
  logic [NUM_INPUTS-1:0]   r_act [NUM_OUTPUTS];

  logic                    w_idle;
  logic                    w_wr_fire;
  logic                    w_addr_ok;
  logic                    w_wr_ok;
  logic                    w_wr_bad;
  logic                    w_commit;
  logic                    w_start_clear;
  logic                    w_last;
  logic [NUM_OUTPUTS-1:0]  w_wsel;
  logic [NUM_OUTPUTS-1:0]  w_csel;

  assign w_idle        = (r_state == IDLE);
  assign cfg_ready     = w_idle && !cfg_clear;
  assign busy          = (r_state == CLEAR);
  assign cfg_err       = r_cfg_err;

  assign w_wr_fire     = cfg_valid && cfg_ready;
  assign w_addr_ok     = ({1'b0, cfg_addr} < NUM_OUT_W);
  assign w_wr_ok       = w_wr_fire && w_addr_ok;
  assign w_wr_bad      = w_wr_fire && !w_addr_ok;
  // Clear takes priority over commit in the same cycle.
  assign w_commit      = w_idle && cfg_commit && !cfg_clear;
  assign w_start_clear = w_idle && cfg_clear;
  assign w_last        = (r_idx == LAST_IDX);

  // Per-output write select and sweep select decode.
  always_comb begin
    w_wsel = '0;
    w_csel = '0;
    for (int o = 0; o < NUM_OUTPUTS; o++) begin
      w_wsel[o] = w_wr_ok && (cfg_addr == AW'(o));
      w_csel[o] = busy && (r_idx == AW'(o));
    end
  end

  // Next-state logic: IDLE -> CLEAR on clear request, back after the last index.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start_clear) w_state_nxt = CLEAR;
      CLEAR:   if (w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, sweep index and error pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cfg_err <= w_wr_bad;
      if (w_start_clear) begin
        r_idx <= '0;
      end else if (busy) begin
        r_idx <= w_last ? '0 : r_idx + 1'b1;
      end
    end
  end

  // Mask storage: sweep restore, shadow write, commit (forwarding a same-cycle write).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int o = 0; o < NUM_OUTPUTS; o++) begin
        r_shd[o] <= INIT;
        r_act[o] <= INIT;
      end
    end else begin
      for (int o = 0; o < NUM_OUTPUTS; o++) begin
        if (w_csel[o]) begin
          r_shd[o] <= INIT;
          r_act[o] <= INIT;
        end else begin
          if (w_wsel[o]) begin
            r_shd[o] <= cfg_mask;
          end
          if (w_commit) begin
            r_act[o] <= w_wsel[o] ? cfg_mask : r_shd[o];
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_term
    pal_or_term #(
      .NUM_INPUTS (NUM_INPUTS)
    ) u_term (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a),
      .mask  (r_act[g]),
      .y     (y[g])
    );
  end

endmodule

// File: tb/tb_pal_or_plane.sv
// tb/tb_pal_or_plane.sv - self-checking bench for pal_or_plane (honours PAL_OR_PLANE_REG_OUT_EN)
module tb_pal_or_plane;

  localparam int NI = 5;
  localparam int NO = 5;
  localparam logic [NI-1:0] INITV = 5'b00011;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NI-1:0] a;
  logic [NO-1:0] y;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [2:0]    cfg_addr;
  logic [NI-1:0] cfg_mask;
  logic          cfg_commit;
  logic          cfg_clear;
  logic          busy;
  logic          cfg_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pal_or_plane #(
    .NUM_INPUTS  (NI),
    .NUM_OUTPUTS (NO),
    .INIT        (INITV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a),
    .y          (y),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_addr   (cfg_addr),
    .cfg_mask   (cfg_mask),
    .cfg_commit (cfg_commit),
    .cfg_clear  (cfg_clear),
    .busy       (busy),
    .cfg_err    (cfg_err)
  );

  // Reference model: mask arrays plus a count of sweep cycles still to run.
  logic [NI-1:0] m_shd [NO];
  logic [NI-1:0] m_act [NO];
  int            m_sweep_left = 0;
  bit            m_err = 0;
  logic [NO-1:0] m_yreg = '0;
  bit            m_valid = 0;

  function automatic logic [NO-1:0] plane(input logic [NI-1:0] av);
    logic [NO-1:0] r;
    for (int o = 0; o < NO; o++) r[o] = ((av & m_act[o]) != '0);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    end
  endtask

  task automatic model_check();
    logic [NO-1:0] ey;
`ifdef PAL_OR_PLANE_REG_OUT_EN
    ey = m_yreg;
`else
    ey = plane(a);
`endif
    chk("mdl_y", 32'(y), 32'(ey));
    chk("mdl_busy", 32'(busy), 32'(m_sweep_left > 0));
    chk("mdl_ready", 32'(cfg_ready), 32'((m_sweep_left == 0) && !cfg_clear));
    chk("mdl_err", 32'(cfg_err), 32'(m_err));
  endtask

  task automatic model_step();
    int p;
    if (!rst_n) begin
      for (int o = 0; o < NO; o++) begin
        m_shd[o] = INITV;
        m_act[o] = INITV;
      end
      m_sweep_left = 0;
      m_err = 0;
      m_yreg = '0;
    end else begin
      m_yreg = plane(a);
      m_err = 0;
      if (m_sweep_left > 0) begin
        p = NO - m_sweep_left;
        m_shd[p] = INITV;
        m_act[p] = INITV;
        m_sweep_left--;
      end else if (cfg_clear) begin
        m_sweep_left = NO;
      end else begin
        if (cfg_valid) begin
          if (int'(cfg_addr) < NO) m_shd[cfg_addr] = cfg_mask;
          else m_err = 1;
        end
        if (cfg_commit) begin
          for (int o = 0; o < NO; o++) m_act[o] = m_shd[o];
        end
      end
    end
  endtask

  // One clock: check pre-edge outputs against the model, step, land on negedge.
  task automatic cyc();
    #1;
    if (m_valid) model_check();
    @(posedge clk);
    model_step();
    m_valid = 1;
    @(negedge clk);
  endtask

  task automatic drv(input bit r, input bit v, input int ad, input int m,
                     input bit c, input bit cl, input int av);
    rst_n      = r;
    cfg_valid  = v;
    cfg_addr   = 3'(ad);
    cfg_mask   = 5'(m);
    cfg_commit = c;
    cfg_clear  = cl;
    a          = 5'(av);
  endtask

  typedef struct {
    bit       r, v;
    int       ad, m;
    bit       c, cl;
    int       av, ey;
    bit       eerr, ebusy, erdy;
  } vec_t;

  vec_t tbl[10];
  int   n_busy;

  task automatic set_vec(input int i, input bit r, input bit v, input int ad, input int m,
                         input bit c, input bit cl, input int av, input int ey,
                         input bit eerr, input bit ebusy, input bit erdy);
    tbl[i] = '{r, v, ad, m, c, cl, av, ey, eerr, ebusy, erdy};
  endtask

  initial begin
    //          i  r  v  ad m        c  cl a        ey       err busy rdy
    set_vec(0, 0, 0, 0, 'b00000, 0, 0, 'b00010, 'b11111, 0, 0, 1);
    set_vec(1, 1, 0, 0, 'b00000, 0, 0, 'b00010, 'b11111, 0, 0, 1);
    set_vec(2, 1, 0, 0, 'b00000, 0, 0, 'b10000, 'b00000, 0, 0, 1);
    set_vec(3, 1, 1, 2, 'b10000, 0, 0, 'b10000, 'b00000, 0, 0, 1);
    set_vec(4, 1, 0, 0, 'b00000, 1, 0, 'b10000, 'b00100, 0, 0, 1);
    set_vec(5, 1, 1, 0, 'b00100, 1, 0, 'b00100, 'b00001, 0, 0, 1);
    set_vec(6, 1, 1, 6, 'b11111, 0, 0, 'b00100, 'b00001, 1, 0, 1);
    set_vec(7, 1, 0, 0, 'b00000, 0, 0, 'b00100, 'b00001, 0, 0, 1);
    set_vec(8, 1, 0, 0, 'b00000, 1, 0, 'b00001, 'b11010, 0, 0, 1);
    set_vec(9, 1, 0, 0, 'b00000, 0, 1, 'b00001, 'b11010, 0, 1, 0);

    drv(0, 0, 0, 0, 0, 0, 'b00010);
    for (int i = 0; i < 10; i++) begin
      drv(tbl[i].r, tbl[i].v, tbl[i].ad, tbl[i].m, tbl[i].c, tbl[i].cl, tbl[i].av);
      cyc();
`ifndef PAL_OR_PLANE_REG_OUT_EN
      chk($sformatf("vec%0d_y", i), 32'(y), 32'(tbl[i].ey));
`endif
      chk($sformatf("vec%0d_err", i), 32'(cfg_err), 32'(tbl[i].eerr));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].ebusy));
      chk($sformatf("vec%0d_ready", i), 32'(cfg_ready), 32'(tbl[i].erdy));
    end

    // Sweep: a write held throughout must be dropped; busy lasts NO cycles.
    n_busy = 1;
    drv(1, 1, 0, 'b11100, 0, 0, 'b11100);
    for (int i = 0; i < 12 && busy === 1'b1; i++) begin
      cyc();
      if (busy === 1'b1) begin
        n_busy++;
        chk("sweep_ready", 32'(cfg_ready), 32'd0);
      end
    end
    chk("sweep_len", 32'(n_busy), 32'(NO));
    drv(1, 0, 0, 0, 0, 0, 'b11100);
    cyc();
    chk("sweep_act_init", 32'(y), 32'b00000);
    drv(1, 0, 0, 0, 1, 0, 'b11100);
    cyc();
    drv(1, 0, 0, 0, 0, 0, 'b11100);
    cyc();
    chk("sweep_shd_init", 32'(y), 32'b00000);
    drv(1, 0, 0, 0, 0, 0, 'b00011);
    cyc();
    cyc();
    chk("sweep_y_hi", 32'(y), 32'b11111);

    // Reset during the third sweep cycle.
    drv(1, 1, 3, 'b11100, 1, 0, 'b11100);
    cyc();
    drv(1, 0, 0, 0, 0, 0, 'b11100);
    cyc();
    chk("rst_pre_y", 32'(y), 32'b01000);
    drv(1, 0, 0, 0, 0, 1, 'b11100);
    cyc();
    drv(1, 0, 0, 0, 0, 0, 'b11100);
    cyc();
    cyc();
    drv(0, 0, 0, 0, 0, 0, 'b11100);
    cyc();
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_ready", 32'(cfg_ready), 32'd1);
    drv(1, 0, 0, 0, 1, 0, 'b11100);
    cyc();
    drv(1, 0, 0, 0, 0, 0, 'b11100);
    cyc();
    chk("rst_mid_y", 32'(y), 32'b00000);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      drv(($urandom_range(0, 63) != 0), ($urandom_range(0, 1) == 1), int'($urandom_range(0, 7)),
          int'($urandom_range(0, 31)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
          int'($urandom_range(0, 31)));
      cyc();
    end
    drv(1, 0, 0, 0, 0, 0, 0);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
